conv_result_drain: RTL

CONV_RESULT_DRAIN -- requirements
Module: conv_result_drain

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_result_drain_if.sv | 33 +++
 rtl/conv_result_drain_sync_fifo.sv | 46 ++++
 rtl/conv_result_drain.sv | 103 ++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result path: default word and
// length widths, and the drain controller state encoding.
package conv_pkg;

    localparam int unsigned CONV_DATA_WIDTH = 16;
    localparam int unsigned CONV_LEN_WIDTH  = 16;

    typedef logic [1:0] drain_state_t;

    localparam drain_state_t ST_IDLE  = 2'd0;
    localparam drain_state_t ST_RUN   = 2'd1;
    localparam drain_state_t ST_FLUSH = 2'd2;
    localparam drain_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/conv_result_drain_if.sv
// Handshake bundle between the convolution datapath, the result drain and
// the downstream consumer. The slave side is the drain itself.
interface conv_result_drain_if
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int LEN_WIDTH  = CONV_LEN_WIDTH
) ();

    logic                  start;
    logic [LEN_WIDTH-1:0]  frame_len;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  frame_done;
    logic                  overflow;

    modport master (
        output start, frame_len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, frame_done, overflow
    );

    modport slave (
        input  start, frame_len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, frame_done, overflow
    );

endinterface

// File: rtl/conv_result_drain_sync_fifo.sv
// Single-clock first-word fall-through FIFO. Pointers carry one extra wrap
// bit so that full and empty are distinguishable without a separate count.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Advance read/write pointers; reset discards all buffered words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Status flags and head-of-queue word.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head  = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/conv_result_drain.sv
// Drains convolution results for one frame into a small buffer and forwards
// them downstream, marking the last word of the frame and pulsing
// frame_done once it has been consumed.
module conv_result_drain
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = CONV_LEN_WIDTH
) (
    input logic               clk,
    input logic               reset,
    conv_result_drain_if.slave bus
);

    drain_state_t          state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  acc_cnt;
    logic [LEN_WIDTH-1:0]  emit_cnt;
    logic [LEN_WIDTH-1:0]  acc_next;
    logic [LEN_WIDTH-1:0]  emit_next;
    logic                  overflow_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  in_ready;
    logic                  out_valid;
    logic                  push;
    logic                  pop;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Handshake qualification and next counter values.
    always_comb begin
        in_ready  = (state == ST_RUN) && !fifo_full;
        out_valid = !fifo_empty;
        push      = bus.in_valid && in_ready;
        pop       = out_valid && bus.out_ready;
        acc_next  = acc_cnt + LEN_WIDTH'(1);
        emit_next = emit_cnt + LEN_WIDTH'(1);
    end

    // Frame sequencing, result counters and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            acc_cnt    <= '0;
            emit_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Counted before the case so an accepted start's clear takes priority.
            if (pop) emit_cnt <= emit_next;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        len_q      <= bus.frame_len;
                        acc_cnt    <= '0;
                        emit_cnt   <= '0;
                        overflow_q <= 1'b0;
                        state      <= (bus.frame_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        acc_cnt <= acc_next;
                        if (acc_next == len_q) state <= ST_FLUSH;
                    end
                    if (bus.in_valid && !in_ready) overflow_q <= 1'b1;
                end
                ST_FLUSH: begin
                    if (pop && (emit_next == len_q)) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output drive; out_data is forced to zero whenever nothing is buffered.
    always_comb begin
        bus.in_ready   = in_ready;
        bus.out_valid  = out_valid;
        bus.out_data   = out_valid ? fifo_head : '0;
        bus.out_last   = out_valid && (emit_cnt == (len_q - LEN_WIDTH'(1)));
        bus.busy       = (state != ST_IDLE);
        bus.frame_done = (state == ST_DONE);
        bus.overflow   = overflow_q;
    end

endmodule
